// File: rtl/delay_adjust_regs_if.sv
// rtl/delay_adjust_regs_if.sv - AXI4-Lite link between the delay-adjust init master and the register bank
interface delay_adjust_regs_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/delay_adjust_regs.sv
// rtl/delay_adjust_regs.sv - AXI4-Lite tap register bank for ADC input delays (option: DELAY_ADJUST_SLVERR_EN)
module delay_adjust_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 8,
  parameter int TAP_WIDTH          = 5
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  delay_adjust_regs_if.slave          s_axi,
  input  logic                        idelay_rdy,
  output logic [NUM_CH*TAP_WIDTH-1:0] tap_value,
  output logic [NUM_CH-1:0]           tap_load
);

  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;

`ifdef DELAY_ADJUST_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [WORD_W-1:0]             w_idx;
  logic [WORD_W-1:0]             r_idx;
  logic                          w_fire;
  logic                          r_fire;
  logic                          w_is_tap;
  logic                          w_ok;
  logic                          r_ok;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data_n;
  logic                          unused_bits;

  assign w_idx = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign r_idx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  // Address and data are only taken together, so a lone AW or W never sees READY.
  assign w_fire        = (w_state == W_IDLE) && s_axi.awvalid && s_axi.wvalid;
  assign s_axi.awready = w_fire;
  assign s_axi.wready  = w_fire;

  assign r_fire        = (r_state == R_IDLE) && s_axi.arvalid;
  assign s_axi.arready = r_fire;

  assign unused_bits = ^{s_axi.wdata[C_S_AXI_DATA_WIDTH-1:TAP_WIDTH], s_axi.wstrb[C_S_AXI_DATA_WIDTH/8-1:1],
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write decode: CTRL and TAP words are the only writable targets; STATUS counts as an error target.
  always_comb begin
    w_is_tap = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(w_idx) == i + 2) w_is_tap = 1'b1;
    end
    w_ok = (w_idx == '0) || w_is_tap;
  end

  // Read mux: unmapped words return zero with an error response when enabled.
  always_comb begin
    r_data_n = '0;
    r_ok     = 1'b0;
    if (r_idx == '0) begin
      r_ok = 1'b1;
    end else if (int'(r_idx) == 1) begin
      r_ok        = 1'b1;
      r_data_n[0] = idelay_rdy;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(r_idx) == i + 2) begin
        r_ok                     = 1'b1;
        r_data_n[TAP_WIDTH-1:0]  = tap_value[i*TAP_WIDTH +: TAP_WIDTH];
      end
    end
  end

  // Write FSM: perform the register update on acceptance, then hold BVALID until BREADY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state      <= W_IDLE;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp  <= 2'b00;
      tap_value    <= '0;
      tap_load     <= '0;
    end else begin
      tap_load <= '0;
      case (w_state)
        W_IDLE: begin
          if (w_fire) begin
            w_state      <= W_RESP;
            s_axi.bvalid <= 1'b1;
            s_axi.bresp  <= w_ok ? 2'b00 : ERR_RESP;
            if (s_axi.wstrb[0]) begin
              if ((w_idx == '0) && s_axi.wdata[0]) tap_load <= '1;
              for (int i = 0; i < NUM_CH; i++) begin
                if (int'(w_idx) == i + 2) begin
                  tap_value[i*TAP_WIDTH +: TAP_WIDTH] <= s_axi.wdata[TAP_WIDTH-1:0];
                  tap_load[i]                         <= 1'b1;
                end
              end
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            w_state      <= W_IDLE;
            s_axi.bvalid <= 1'b0;
            s_axi.bresp  <= 2'b00;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: capture data at acceptance so a same-cycle write is not visible until the next read.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state      <= R_IDLE;
      s_axi.rvalid <= 1'b0;
      s_axi.rdata  <= '0;
      s_axi.rresp  <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (r_fire) begin
            r_state      <= R_DATA;
            s_axi.rvalid <= 1'b1;
            s_axi.rdata  <= r_data_n;
            s_axi.rresp  <= r_ok ? 2'b00 : ERR_RESP;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            r_state      <= R_IDLE;
            s_axi.rvalid <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_adjust_regs.sv
// tb/tb_delay_adjust_regs.sv - self-checking bench for delay_adjust_regs
module tb_delay_adjust_regs;

`ifdef DELAY_ADJUST_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  localparam int NCH   = 8;
  localparam int TW    = 5;
  localparam int LIMIT = 20;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              idelay_rdy;
  logic [NCH*TW-1:0] tap_value;
  logic [NCH-1:0]    tap_load;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  delay_adjust_regs_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) axi ();

  delay_adjust_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_CH(NCH),
    .TAP_WIDTH(TW)
  ) dut (
    .ACLK(aclk),
    .ARESETN(aresetn),
    .s_axi(axi),
    .idelay_rdy(idelay_rdy),
    .tap_value(tap_value),
    .tap_load(tap_load)
  );

  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_load;
  } vec_t;

  vec_t vecs[15];
  logic [TW-1:0] model[NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [7:0] load);
    int n;
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.bready  = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!(axi.awready && axi.wready) && n < LIMIT) begin
      n++;
      @(negedge aclk);
    end
    check("write_accept_timeout", 64'(n >= LIMIT), 64'd0);
    @(posedge aclk);
    #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    @(negedge aclk);
    check("bvalid_after_accept", 64'(axi.bvalid), 64'd1);
    resp = axi.bresp;
    load = tap_load;
    @(negedge aclk);
    check("tap_load_one_cycle", 64'(tap_load), 64'd0);
    check("bvalid_released", 64'(axi.bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!axi.arready && n < LIMIT) begin
      n++;
      @(negedge aclk);
    end
    check("read_accept_timeout", 64'(n >= LIMIT), 64'd0);
    @(posedge aclk);
    #1;
    axi.arvalid = 1'b0;
    @(negedge aclk);
    check("rvalid_after_accept", 64'(axi.rvalid), 64'd1);
    data = axi.rdata;
    resp = axi.rresp;
    @(negedge aclk);
    check("rvalid_released", 64'(axi.rvalid), 64'd0);
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 64'(axi.awready), 64'd0);
    check("rst_wready", 64'(axi.wready), 64'd0);
    check("rst_bvalid", 64'(axi.bvalid), 64'd0);
    check("rst_arready", 64'(axi.arready), 64'd0);
    check("rst_rvalid", 64'(axi.rvalid), 64'd0);
    check("rst_bresp_rresp", 64'({axi.bresp, axi.rresp}), 64'd0);
    check("rst_rdata", 64'(axi.rdata), 64'd0);
    check("rst_tap_value", 64'(tap_value), 64'd0);
    check("rst_tap_load", 64'(tap_load), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  function automatic logic [NCH*TW-1:0] model_taps();
    logic [NCH*TW-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*TW +: TW] = model[i];
    return v;
  endfunction

  function automatic bit is_tap_word(int w);
    return (w >= 2) && (w < 2 + NCH);
  endfunction

  initial begin
    logic [1:0]  resp;
    logic [7:0]  load;
    logic [31:0] rd;

    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    idelay_rdy = 1'b0;
    aresetn    = 1'b0;

    vecs[0]  = '{1'b0, 6'h08, 32'h0,        4'hF, 32'h0,  2'b00, 8'h00};
    vecs[1]  = '{1'b1, 6'h14, 32'h15,       4'hF, 32'h0,  2'b00, 8'h08};
    vecs[2]  = '{1'b0, 6'h14, 32'h0,        4'hF, 32'h15, 2'b00, 8'h00};
    vecs[3]  = '{1'b1, 6'h00, 32'h1,        4'hF, 32'h0,  2'b00, 8'hFF};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,        4'hF, 32'h0,  2'b00, 8'h00};
    vecs[5]  = '{1'b1, 6'h0C, 32'h04,       4'hF, 32'h0,  2'b00, 8'h02};
    vecs[6]  = '{1'b1, 6'h0C, 32'hFFFFFFFF, 4'hE, 32'h0,  2'b00, 8'h00};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0,        4'hF, 32'h04, 2'b00, 8'h00};
    vecs[8]  = '{1'b1, 6'h24, 32'hFFFFFFE3, 4'hF, 32'h0,  2'b00, 8'h80};
    vecs[9]  = '{1'b0, 6'h24, 32'h0,        4'hF, 32'h03, 2'b00, 8'h00};
    vecs[10] = '{1'b1, 6'h04, 32'h5,        4'hF, 32'h0,  ERR,   8'h00};
    vecs[11] = '{1'b1, 6'h3C, 32'h7,        4'hF, 32'h0,  ERR,   8'h00};
    vecs[12] = '{1'b0, 6'h3C, 32'h0,        4'hF, 32'h0,  ERR,   8'h00};
    vecs[13] = '{1'b0, 6'h28, 32'h0,        4'hF, 32'h0,  ERR,   8'h00};
    vecs[14] = '{1'b1, 6'h00, 32'h0,        4'hF, 32'h0,  2'b00, 8'h00};

    apply_reset();

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, load);
        check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
        check($sformatf("vec%0d_tap_load", i), 64'(load), 64'(vecs[i].exp_load));
      end else begin
        do_read(vecs[i].addr, rd, resp);
        check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
        check($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vecs[i].exp_resp));
      end
    end
    check("table_tap_value", 64'(tap_value),
          64'((40'd3 << 35) | (40'd21 << 15) | (40'd4 << 5)));

    idelay_rdy = 1'b1;
    do_read(6'h04, rd, resp);
    check("status_rdy1", 64'(rd), 64'd1);
    idelay_rdy = 1'b0;
    do_read(6'h04, rd, resp);
    check("status_rdy0", 64'(rd), 64'd0);

    // AW leads W by three cycles, then BREADY held low for four cycles.
    axi.awaddr  = 6'h10;
    axi.wdata   = 32'h11;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check("aw_only_no_ready", 64'({axi.awready, axi.wready}), 64'd0);
    end
    axi.wvalid = 1'b1;
    #1;
    check("aw_w_ready", 64'({axi.awready, axi.wready}), 64'd3);
    @(posedge aclk);
    #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    @(negedge aclk);
    check("late_w_load", 64'(tap_load), 64'h04);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
      check("bvalid_held", 64'(axi.bvalid), 64'd1);
      check("hold_no_reload", 64'(tap_load), 64'd0);
    end
    axi.bready = 1'b1;
    @(negedge aclk);
    check("bvalid_after_bready", 64'(axi.bvalid), 64'd0);
    do_read(6'h10, rd, resp);
    check("late_w_readback", 64'(rd), 64'h11);

    // Same-cycle write and read of TAP[1] returns the old value.
    axi.awaddr  = 6'h0C;
    axi.wdata   = 32'h0A;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.araddr  = 6'h0C;
    axi.arvalid = 1'b1;
    #1;
    check("both_ready", 64'({axi.awready, axi.arready}), 64'd3);
    @(posedge aclk);
    #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.arvalid = 1'b0;
    @(negedge aclk);
    check("simul_rdata_old", 64'(axi.rdata), 64'h04);
    check("simul_valids", 64'({axi.bvalid, axi.rvalid}), 64'd3);
    check("simul_load", 64'(tap_load), 64'h02);
    @(negedge aclk);
    do_read(6'h0C, rd, resp);
    check("simul_rdata_new", 64'(rd), 64'h0A);

    // Back-to-back writes to one channel give separate pulses.
    for (int k = 0; k < 2; k++) begin
      do_write(6'h08, 32'(k + 1), 4'hF, resp, load);
      check("b2b_load", 64'(load), 64'h01);
    end

    // Randomised traffic against a register-map model.
    apply_reset();
    for (int i = 0; i < NCH; i++) model[i] = '0;
    for (int it = 0; it < 200; it++) begin
      int          w;
      logic [31:0] d;
      logic [3:0]  s;
      logic [7:0]  exp_load;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
      w          = $urandom_range(0, 15);
      idelay_rdy = 1'($urandom_range(0, 1));
      exp_resp   = ((w == 0) || is_tap_word(w)) ? 2'b00 : ERR;
      if ($urandom_range(0, 1) == 1) begin
        d        = $urandom;
        s        = 4'($urandom_range(0, 15));
        exp_load = 8'h00;
        if (s[0]) begin
          if (w == 0 && d[0]) exp_load = 8'hFF;
          if (is_tap_word(w)) begin
            exp_load     = 8'(1 << (w - 2));
            model[w - 2] = d[TW-1:0];
          end
        end
        do_write(6'(w * 4), d, s, resp, load);
        check("rand_bresp", 64'(resp), 64'(exp_resp));
        check("rand_load", 64'(load), 64'(exp_load));
        check("rand_taps", 64'(tap_value), 64'(model_taps()));
      end else begin
        exp_data = 32'h0;
        if (w == 1) exp_data = 32'(idelay_rdy);
        if (is_tap_word(w)) exp_data = 32'(model[w - 2]);
        do_read(6'(w * 4), rd, resp);
        check("rand_rdata", 64'(rd), 64'(exp_data));
        check("rand_rresp", 64'(resp), 64'(exp_resp));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
